// File: rtl/dot_square_motion_ctrl_pkg.sv
// Shared definitions for the rectangle-layer motion controller: register map,
// control bits, update FSM encoding and coordinate/velocity widths.
package dot_square_motion_ctrl_pkg;

    localparam int H_DISPLAY_W = 11;
    localparam int V_DISPLAY_W = 11;
    localparam int H_COORD_W   = H_DISPLAY_W + 1;
    localparam int V_COORD_W   = V_DISPLAY_W + 1;
    localparam int VEL_W       = 8;
    localparam int COLOR_W     = 16;
    localparam int REG_ADDR_W  = 3;
    localparam int REG_DATA_W  = 16;

    localparam logic [REG_ADDR_W-1:0] ADDR_X     = 3'd0;
    localparam logic [REG_ADDR_W-1:0] ADDR_Y     = 3'd1;
    localparam logic [REG_ADDR_W-1:0] ADDR_W     = 3'd2;
    localparam logic [REG_ADDR_W-1:0] ADDR_H     = 3'd3;
    localparam logic [REG_ADDR_W-1:0] ADDR_VX    = 3'd4;
    localparam logic [REG_ADDR_W-1:0] ADDR_VY    = 3'd5;
    localparam logic [REG_ADDR_W-1:0] ADDR_COLOR = 3'd6;
    localparam logic [REG_ADDR_W-1:0] ADDR_CTRL  = 3'd7;

    localparam int CTRL_MOVE_EN  = 0;
    localparam int CTRL_LOAD_POS = 1;
    localparam int CTRL_MISS_CLR = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC_X = 2'd1,
        ST_CALC_Y = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/dot_square_motion_ctrl_if.sv
// Register write bus of the motion controller. A write takes effect on the
// clock edge where iWe is high; there is no back-pressure (always accepted).
interface dot_square_motion_ctrl_if;
    import dot_square_motion_ctrl_pkg::*;

    logic                  iWe;
    logic [REG_ADDR_W-1:0] iAddr;
    logic [REG_DATA_W-1:0] iWdata;

    modport master (output iWe, iAddr, iWdata);
    modport slave  (input  iWe, iAddr, iWdata);
endinterface

// File: rtl/dot_square_axis_step.sv
// One-axis position/velocity update: load, or move with clamp followed by edge
// reflection (SQUARE_BOUNCE_EN defined) or off-screen wrap-around (default).
module dot_square_axis_step #(
    parameter int pCoordW  = 12,
    parameter int pSizeW   = 11,
    parameter int pVelW    = 8,
    parameter int pDisplay = 320
) (
    input  logic signed [pCoordW-1:0] pos_i,
    input  logic signed [pCoordW-1:0] staged_i,
    input  logic signed [pVelW-1:0]   vel_i,
    input  logic        [pSizeW-1:0]  size_i,
    input  logic                      load_i,
    input  logic                      move_i,
    output logic signed [pCoordW-1:0] pos_o,
    output logic signed [pVelW-1:0]   vel_o
);

    // Two guard bits so pos+vel and pos+size never overflow before clamping.
    localparam int SW = pCoordW + 2;
    localparam logic signed [SW-1:0] C_MAX = SW'(2 ** (pCoordW - 1) - 1);
    localparam logic signed [SW-1:0] C_MIN = SW'(-(2 ** (pCoordW - 1)));
    localparam logic signed [SW-1:0] DISP  = SW'(pDisplay);
    localparam logic signed [SW-1:0] ZERO  = '0;
`ifdef SQUARE_BOUNCE_EN
    localparam logic signed [pVelW-1:0] V_MAX = pVelW'(2 ** (pVelW - 1) - 1);
    localparam logic signed [pVelW-1:0] V_MIN = {1'b1, {(pVelW - 1){1'b0}}};
    logic signed [pVelW-1:0] vel_neg;
`else
    localparam logic signed [SW-1:0] DISP_M1 = SW'(pDisplay - 1);
`endif

    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    moved;
    logic signed [SW-1:0]    size_s;
    logic signed [SW-1:0]    nxt;
    logic signed [pVelW-1:0] vel_nxt;

    always_comb begin
        sum     = SW'(pos_i) + SW'(vel_i);
        size_s  = SW'(size_i);
        if (sum > C_MAX) begin
            moved = C_MAX;
        end else if (sum < C_MIN) begin
            moved = C_MIN;
        end else begin
            moved = sum;
        end
        nxt     = moved;
        vel_nxt = vel_i;
`ifdef SQUARE_BOUNCE_EN
        vel_neg = (vel_i == V_MIN) ? V_MAX : -vel_i;
        if (moved < ZERO) begin
            nxt     = ZERO;
            vel_nxt = vel_neg;
        end else if (moved + size_s > DISP) begin
            nxt     = DISP - size_s;
            vel_nxt = vel_neg;
        end
`else
        if (moved >= DISP) begin
            nxt = -size_s;
        end else if (moved + size_s <= ZERO) begin
            nxt = DISP_M1;
        end
`endif
        // Edge handling applies to motion only; a loaded position is taken as-is.
        pos_o = pos_i;
        vel_o = vel_i;
        if (load_i) begin
            pos_o = staged_i;
        end else if (move_i) begin
            pos_o = nxt[pCoordW-1:0];
            vel_o = vel_nxt;
        end
    end

endmodule

// File: rtl/dot_square_motion_ctrl.sv
// Per-frame rectangle sequencer: staged register writes are integrated and
// committed as tear-free draw bounds once per vblank. Option: SQUARE_BOUNCE_EN.
module dot_square_motion_ctrl
    import dot_square_motion_ctrl_pkg::*;
#(
    parameter int pHdisplayWidth = H_DISPLAY_W,
    parameter int pVdisplayWidth = V_DISPLAY_W,
    parameter int pColorDepth    = COLOR_W,
    parameter int pHdisplay      = 320,
    parameter int pVdisplay      = 240,
    parameter int pVelWidth      = VEL_W
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iFrameStart,
    dot_square_motion_ctrl_if.slave       bus,
    output logic signed [pHdisplayWidth:0] oDLeftX,
    output logic signed [pHdisplayWidth:0] oDRightX,
    output logic signed [pVdisplayWidth:0] oDTopY,
    output logic signed [pVdisplayWidth:0] oDUnderY,
    output logic [pColorDepth-1:0]        oColor,
    output logic                          oBusy,
    output logic                          oMissFrame,
    output state_e                        oDbgState
);

    localparam int CXW = pHdisplayWidth + 1;
    localparam int CYW = pVdisplayWidth + 1;
    localparam int XSW = CXW + 1;
    localparam int YSW = CYW + 1;
    localparam logic signed [XSW-1:0] X_MAX = XSW'(2 ** (CXW - 1) - 1);
    localparam logic signed [YSW-1:0] Y_MAX = YSW'(2 ** (CYW - 1) - 1);

    state_e state_q, state_d;

    logic signed [CXW-1:0]       stg_x_q, stg_x_d;
    logic signed [CYW-1:0]       stg_y_q, stg_y_d;
    logic [pHdisplayWidth-1:0]   stg_w_q, stg_w_d;
    logic [pVdisplayWidth-1:0]   stg_h_q, stg_h_d;
    logic signed [pVelWidth-1:0] stg_vx_q, stg_vx_d, stg_vy_q, stg_vy_d;
    logic [pColorDepth-1:0]      stg_col_q, stg_col_d;
    logic                        stg_move_q, stg_move_d;
    logic                        stg_load_q, stg_load_w, stg_load_d;
    logic                        vx_pend_q, vx_pend_w, vx_pend_d;
    logic                        vy_pend_q, vy_pend_w, vy_pend_d;
    logic                        miss_clr;

    logic signed [CXW-1:0]       pos_x_q, step_x_pos;
    logic signed [CYW-1:0]       pos_y_q, step_y_pos;
    logic signed [pVelWidth-1:0] vel_x_q, vel_y_q, vel_x_eff, step_x_vel, step_y_vel;

    logic signed [CYW-1:0]       snp_y_q;
    logic [pHdisplayWidth-1:0]   snp_w_q;
    logic [pVdisplayWidth-1:0]   snp_h_q;
    logic signed [pVelWidth-1:0] snp_vy_q;
    logic [pColorDepth-1:0]      snp_col_q;
    logic                        snp_load_q, snp_move_q;

    logic signed [XSW-1:0]       rx_sum;
    logic signed [YSW-1:0]       uy_sum;
    logic signed [CXW-1:0]       left_q, right_q, right_d;
    logic signed [CYW-1:0]       top_q, under_q, under_d;
    logic [pColorDepth-1:0]      color_q;
    logic                        miss_q;

    // Register writes; *_w is the write-forwarded view that CALC_X samples.
    always_comb begin
        stg_x_d    = stg_x_q;
        stg_y_d    = stg_y_q;
        stg_w_d    = stg_w_q;
        stg_h_d    = stg_h_q;
        stg_vx_d   = stg_vx_q;
        stg_vy_d   = stg_vy_q;
        stg_col_d  = stg_col_q;
        stg_move_d = stg_move_q;
        stg_load_w = stg_load_q;
        vx_pend_w  = vx_pend_q;
        vy_pend_w  = vy_pend_q;
        miss_clr   = 1'b0;
        if (bus.iWe) begin
            case (bus.iAddr)
                ADDR_X:     stg_x_d = bus.iWdata[CXW-1:0];
                ADDR_Y:     stg_y_d = bus.iWdata[CYW-1:0];
                ADDR_W:     stg_w_d = bus.iWdata[pHdisplayWidth-1:0];
                ADDR_H:     stg_h_d = bus.iWdata[pVdisplayWidth-1:0];
                ADDR_VX: begin
                    stg_vx_d  = bus.iWdata[pVelWidth-1:0];
                    vx_pend_w = 1'b1;
                end
                ADDR_VY: begin
                    stg_vy_d  = bus.iWdata[pVelWidth-1:0];
                    vy_pend_w = 1'b1;
                end
                ADDR_COLOR: stg_col_d = bus.iWdata[pColorDepth-1:0];
                ADDR_CTRL: begin
                    stg_move_d = bus.iWdata[CTRL_MOVE_EN];
                    stg_load_w = bus.iWdata[CTRL_LOAD_POS];
                    miss_clr   = bus.iWdata[CTRL_MISS_CLR];
                end
                default: ;
            endcase
        end
        // The frame consumes LOAD_POS and any pending velocity at snapshot time.
        stg_load_d = stg_load_w;
        vx_pend_d  = vx_pend_w;
        vy_pend_d  = vy_pend_w;
        if (state_q == ST_CALC_X) begin
            stg_load_d = 1'b0;
            vx_pend_d  = 1'b0;
            vy_pend_d  = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (iFrameStart) state_d = ST_CALC_X;
            ST_CALC_X: state_d = ST_CALC_Y;
            ST_CALC_Y: state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign vel_x_eff = vx_pend_w ? stg_vx_d : vel_x_q;

    dot_square_axis_step #(
        .pCoordW (CXW),
        .pSizeW  (pHdisplayWidth),
        .pVelW   (pVelWidth),
        .pDisplay(pHdisplay)
    ) u_step_x (
        .pos_i   (pos_x_q),
        .staged_i(stg_x_d),
        .vel_i   (vel_x_eff),
        .size_i  (stg_w_d),
        .load_i  (stg_load_w),
        .move_i  (stg_move_d),
        .pos_o   (step_x_pos),
        .vel_o   (step_x_vel)
    );

    dot_square_axis_step #(
        .pCoordW (CYW),
        .pSizeW  (pVdisplayWidth),
        .pVelW   (pVelWidth),
        .pDisplay(pVdisplay)
    ) u_step_y (
        .pos_i   (pos_y_q),
        .staged_i(snp_y_q),
        .vel_i   (snp_vy_q),
        .size_i  (snp_h_q),
        .load_i  (snp_load_q),
        .move_i  (snp_move_q),
        .pos_o   (step_y_pos),
        .vel_o   (step_y_vel)
    );

    // Far edges can only overflow upwards: position >= min and size >= 0.
    always_comb begin
        rx_sum  = XSW'(pos_x_q) + XSW'(snp_w_q);
        uy_sum  = YSW'(pos_y_q) + YSW'(snp_h_q);
        right_d = (rx_sum > X_MAX) ? X_MAX[CXW-1:0] : rx_sum[CXW-1:0];
        under_d = (uy_sum > Y_MAX) ? Y_MAX[CYW-1:0] : uy_sum[CYW-1:0];
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= ST_IDLE;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (iFrameStart && (state_q != ST_IDLE)) begin
                miss_q <= 1'b1;
            end else if (miss_clr) begin
                miss_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            stg_x_q    <= '0;
            stg_y_q    <= '0;
            stg_w_q    <= '0;
            stg_h_q    <= '0;
            stg_vx_q   <= '0;
            stg_vy_q   <= '0;
            stg_col_q  <= '0;
            stg_move_q <= 1'b0;
            stg_load_q <= 1'b0;
            vx_pend_q  <= 1'b0;
            vy_pend_q  <= 1'b0;
        end else begin
            stg_x_q    <= stg_x_d;
            stg_y_q    <= stg_y_d;
            stg_w_q    <= stg_w_d;
            stg_h_q    <= stg_h_d;
            stg_vx_q   <= stg_vx_d;
            stg_vy_q   <= stg_vy_d;
            stg_col_q  <= stg_col_d;
            stg_move_q <= stg_move_d;
            stg_load_q <= stg_load_d;
            vx_pend_q  <= vx_pend_d;
            vy_pend_q  <= vy_pend_d;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            vel_x_q    <= '0;
            vel_y_q    <= '0;
            snp_y_q    <= '0;
            snp_w_q    <= '0;
            snp_h_q    <= '0;
            snp_vy_q   <= '0;
            snp_col_q  <= '0;
            snp_load_q <= 1'b0;
            snp_move_q <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            top_q      <= '0;
            under_q    <= '0;
            color_q    <= '0;
        end else begin
            case (state_q)
                ST_CALC_X: begin
                    pos_x_q    <= step_x_pos;
                    vel_x_q    <= step_x_vel;
                    snp_y_q    <= stg_y_d;
                    snp_w_q    <= stg_w_d;
                    snp_h_q    <= stg_h_d;
                    snp_vy_q   <= vy_pend_w ? stg_vy_d : vel_y_q;
                    snp_col_q  <= stg_col_d;
                    snp_load_q <= stg_load_w;
                    snp_move_q <= stg_move_d;
                end
                ST_CALC_Y: begin
                    pos_y_q <= step_y_pos;
                    vel_y_q <= step_y_vel;
                end
                ST_COMMIT: begin
                    left_q  <= pos_x_q;
                    right_q <= right_d;
                    top_q   <= pos_y_q;
                    under_q <= under_d;
                    color_q <= snp_col_q;
                end
                default: ;
            endcase
        end
    end

    assign oDLeftX    = left_q;
    assign oDRightX   = right_q;
    assign oDTopY     = top_q;
    assign oDUnderY   = under_q;
    assign oColor     = color_q;
    assign oBusy      = (state_q != ST_IDLE);
    assign oMissFrame = miss_q;
    assign oDbgState  = state_q;

endmodule
